// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-panel controller: button sync/debounce plus pause/clear FSM.
// Optional lap (split) mode is built when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned CLEAR_CYCLES    = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_ss_n,
   input  logic       btn_clr_n,
   output logic       pause,
   output logic       clear_n,
   output logic       lap_hold,
   output logic       running,
   output logic [2:0] state
);

   localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int unsigned CL_W    = $clog2(CLEAR_CYCLES) + 1;
   localparam int unsigned BTN_SS  = 0;
   localparam int unsigned BTN_CLR = 1;

   typedef enum logic [2:0] {
      S_CLR  = 3'd0,
      S_IDLE = 3'd1,
      S_RUN  = 3'd2,
      S_HOLD = 3'd3
`ifdef STOPWATCH_LAP_EN
      , S_LAP = 3'd4
`endif
   } state_t;

   logic [1:0]      raw_n;
   logic [1:0]      sync1_q, sync2_q;
   logic [1:0]      deb_q, deb_d;
   logic [1:0]      deb_dly_q;
   logic [1:0]      press_q, press_d;
   logic [DB_W-1:0] db_cnt_q [2];
   logic [DB_W-1:0] db_cnt_d [2];
   logic [CL_W-1:0] clr_cnt_q, clr_cnt_d;
   state_t          state_q, state_d;
   logic            pause_q, pause_d;
   logic            clear_n_q, clear_n_d;
   logic            running_q, running_d;
   logic            ss_press, clr_press;

   assign raw_n     = {btn_clr_n, btn_ss_n};
   assign ss_press  = press_q[BTN_SS];
   assign clr_press = press_q[BTN_CLR];

   // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive mismatching cycles
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         deb_d[i]    = deb_q[i];
         db_cnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               deb_d[i] = sync2_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
         end
         press_d[i] = deb_dly_q[i] & ~deb_q[i];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q   <= 2'b11;
         sync2_q   <= 2'b11;
         deb_q     <= 2'b11;
         deb_dly_q <= 2'b11;
         press_q   <= 2'b00;
         for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
      end else begin
         sync1_q   <= raw_n;
         sync2_q   <= sync1_q;
         deb_q     <= deb_d;
         deb_dly_q <= deb_q;
         press_q   <= press_d;
         for (int i = 0; i < 2; i++) db_cnt_q[i] <= db_cnt_d[i];
      end
   end

   // Next state and registered Moore outputs derived from the next state
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = '0;
      case (state_q)
         S_CLR: begin
            if (clr_cnt_q == CL_W'(CLEAR_CYCLES - 1)) begin
               state_d = S_IDLE;
            end else begin
               clr_cnt_d = clr_cnt_q + CL_W'(1);
            end
         end
         S_IDLE, S_HOLD: begin
            if (clr_press)     state_d = S_CLR;
            else if (ss_press) state_d = S_RUN;
         end
         S_RUN: begin
            if (ss_press) state_d = S_HOLD;
`ifdef STOPWATCH_LAP_EN
            else if (clr_press) state_d = S_LAP;
`endif
         end
`ifdef STOPWATCH_LAP_EN
         S_LAP: begin
            if (ss_press)       state_d = S_HOLD;
            else if (clr_press) state_d = S_RUN;
         end
`endif
         default: state_d = S_CLR;
      endcase

`ifdef STOPWATCH_LAP_EN
      running_d = (state_d == S_RUN) || (state_d == S_LAP);
`else
      running_d = (state_d == S_RUN);
`endif
      pause_d   = ~running_d;
      clear_n_d = (state_d != S_CLR);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_CLR;
         clr_cnt_q <= '0;
         pause_q   <= 1'b1;
         clear_n_q <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         pause_q   <= pause_d;
         clear_n_q <= clear_n_d;
         running_q <= running_d;
      end
   end

`ifdef STOPWATCH_LAP_EN
   logic lap_hold_q, lap_hold_d;
   assign lap_hold_d = (state_d == S_LAP);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) lap_hold_q <= 1'b0;
      else       lap_hold_q <= lap_hold_d;
   end

   assign lap_hold = lap_hold_q;
`else
   assign lap_hold = 1'b0;
`endif

   assign pause   = pause_q;
   assign clear_n = clear_n_q;
   assign running = running_q;
   assign state   = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4, CLEAR_CYCLES=2.
// Press latency is 7 cycles to the pulse, the FSM moves on the 8th edge.
module tb_stopwatch_ctrl;

   localparam logic [2:0] ST_CLR  = 3'd0;
   localparam logic [2:0] ST_IDLE = 3'd1;
   localparam logic [2:0] ST_RUN  = 3'd2;
   localparam logic [2:0] ST_HOLD = 3'd3;
   localparam logic [2:0] ST_LAP  = 3'd4;

   logic       clk;
   logic       reset;
   logic       btn_ss_n;
   logic       btn_clr_n;
   logic       pause;
   logic       clear_n;
   logic       lap_hold;
   logic       running;
   logic [2:0] state;

   int n_chk;
   int n_fail;

   stopwatch_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .CLEAR_CYCLES   (2)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .btn_ss_n (btn_ss_n),
      .btn_clr_n(btn_clr_n),
      .pause    (pause),
      .clear_n  (clear_n),
      .lap_hold (lap_hold),
      .running  (running),
      .state    (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance n rising edges; sample/drive 1 time unit after the last one
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input bit ss, input bit clr);
      if (ss)  btn_ss_n  = 1'b0;
      if (clr) btn_clr_n = 1'b0;
      step(8);
   endtask

   task automatic release_all();
      btn_ss_n  = 1'b1;
      btn_clr_n = 1'b1;
      step(10);
   endtask

   task automatic check_outs(input string tag, input logic [2:0] st, input logic ps,
                             input logic cn, input logic lh, input logic rn);
      check({tag, ".state"},    32'(state),    32'(st));
      check({tag, ".pause"},    32'(pause),    32'(ps));
      check({tag, ".clear_n"},  32'(clear_n),  32'(cn));
      check({tag, ".lap_hold"}, 32'(lap_hold), 32'(lh));
      check({tag, ".running"},  32'(running),  32'(rn));
   endtask

   initial begin
      n_chk     = 0;
      n_fail    = 0;
      reset     = 1'b1;
      btn_ss_n  = 1'b1;
      btn_clr_n = 1'b1;
      #1;
      check_outs("rst", ST_CLR, 1'b1, 1'b0, 1'b0, 1'b0);
      step(2);
      reset = 1'b0;

      // Clear pulse after reset release
      step(1);
      check_outs("clr_c1", ST_CLR, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1);
      check_outs("idle", ST_IDLE, 1'b1, 1'b1, 1'b0, 1'b0);

      // Start: long press gives exactly one transition on edge 8
      btn_ss_n = 1'b0;
      step(7);
      check("start_e7.state", 32'(state), 32'(ST_IDLE));
      step(1);
      check_outs("start_e8", ST_RUN, 1'b0, 1'b1, 1'b0, 1'b1);
      step(12);
      check("start_held.state", 32'(state), 32'(ST_RUN));
      release_all();
      check("start_rel.state", 32'(state), 32'(ST_RUN));

      // Glitch shorter than debounce window is ignored
      btn_ss_n = 1'b0;
      step(3);
      btn_ss_n = 1'b1;
      step(15);
      check("glitch.state", 32'(state), 32'(ST_RUN));

      press(1'b1, 1'b0);
      check_outs("hold", ST_HOLD, 1'b1, 1'b1, 1'b0, 1'b0);
      release_all();
      press(1'b1, 1'b0);
      check_outs("resume", ST_RUN, 1'b0, 1'b1, 1'b0, 1'b1);
      release_all();

`ifdef STOPWATCH_LAP_EN
      press(1'b0, 1'b1);
      check_outs("lap", ST_LAP, 1'b0, 1'b1, 1'b1, 1'b1);
      release_all();
      press(1'b1, 1'b1);
      check_outs("lap_both", ST_HOLD, 1'b1, 1'b1, 1'b0, 1'b0);
      release_all();
`else
      press(1'b0, 1'b1);
      check_outs("run_clr_ign", ST_RUN, 1'b0, 1'b1, 1'b0, 1'b1);
      release_all();
      check("run_clr_rel.state", 32'(state), 32'(ST_RUN));
      press(1'b1, 1'b0);
      check("hold2.state", 32'(state), 32'(ST_HOLD));
      release_all();
`endif

      // Clear from HOLD: two cycles of clear_n low then IDLE
      press(1'b0, 1'b1);
      check_outs("hold_clr", ST_CLR, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1);
      check("hold_clr_c2.clear_n", 32'(clear_n), 32'(1'b0));
      step(1);
      check_outs("hold_clr_idle", ST_IDLE, 1'b1, 1'b1, 1'b0, 1'b0);
      release_all();

      // Simultaneous presses: ss wins in RUN, clr wins in HOLD
      press(1'b1, 1'b0);
      check("run3.state", 32'(state), 32'(ST_RUN));
      release_all();
      press(1'b1, 1'b1);
      check("run_both.state", 32'(state), 32'(ST_HOLD));
      release_all();
      press(1'b1, 1'b1);
      check("hold_both.state", 32'(state), 32'(ST_CLR));
      step(2);
      check("hold_both_idle.state", 32'(state), 32'(ST_IDLE));
      release_all();

      // Reset while running with the button held
      press(1'b1, 1'b0);
      check("run4.state", 32'(state), 32'(ST_RUN));
      release_all();
      btn_ss_n = 1'b0;
      step(3);
      #2;
      reset = 1'b1;
      #1;
      check_outs("async_rst", ST_CLR, 1'b1, 1'b0, 1'b0, 1'b0);
      step(2);
      reset = 1'b0;
      step(1);
      check("post_rst_c1.clear_n", 32'(clear_n), 32'(1'b0));
      step(1);
      check("post_rst_idle.state", 32'(state), 32'(ST_IDLE));
      step(5);
      check("post_rst_e7.state", 32'(state), 32'(ST_IDLE));
      step(1);
      check_outs("post_rst_run", ST_RUN, 1'b0, 1'b1, 1'b0, 1'b1);
      release_all();
      check("final.state", 32'(state), 32'(ST_RUN));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
